reaction_session_ctrl: RTL and testbench
========================================

Name: reaction_session_ctrl

Overview:
Sequences a multi-trial reaction-time session on top of the existing delay/measure datapath: random-delay generator, reaction timer and debounced react input. It arms each trial, classifies the outcome as valid, false start, anticipation or timeout, and enforces an inter-trial gap. It accumulates best, worst and average over 2^LOG2_TRIALS valid trials, and aborts after MAX_FAILS failures. Runs on the divided 1 kHz clock, so one cycle equals 1 ms.

Parameters:
LOG2_TRIALS, 2, log2 of the number of valid trials per session (4).
MIN_VALID, 100, t_react values below this (ms) are anticipations and count as a fail.
GAP_MS, 1000, minimum trial_start-low pause between trials, in cycles.
MAX_FAILS, 3, fail count at which the session aborts (1..255).

Ports:
clock  in  1  divided 1 kHz system clock
reset  in  1  synchronous, active-high reset
session_start  in  1  debounced start level; rising edge starts a session
react  in  1  debounced react level
random_finish  in  1  high once the random delay has elapsed while trial_start is held
react_exceed  in  1  reaction timer timeout flag
t_react  in  32  reaction time in ms from the timer
trial_start  out  1  level held high to run the delay generator; low clears it
trial_idx  out  LOG2_TRIALS+1  number of valid trials completed
busy  out  1  session in progress
false_start  out  1  one-cycle pulse on react during the delay
fail_count  out  8  failed trials this session
best_time  out  32  minimum valid t_react
worst_time  out  32  maximum valid t_react
avg_time  out  32  sum of valid times >> LOG2_TRIALS; meaningful only when session_done and not session_abort
session_done  out  1  session finished (complete or aborted)
session_abort  out  1  session ended by MAX_FAILS

Behaviour:
- Reset (synchronous): all outputs 0; state IDLE; internal sum (32+LOG2_TRIALS bits), gap counter and session_start edge register cleared. Applies mid-operation; trial_start is low in the cycle after reset is sampled.
- Edge detect: the session_start edge is registered. Edges seen in any state other than IDLE or DONE are ignored.
- IDLE / DONE, on edge:
  - clear stats, fail_count, trial_idx, session_done and session_abort;
  - set busy = 1;
  - go to ARM.
- ARM (trial_start = 1):
  - random_finish = 1 -> MEASURE. This takes priority over react in the same cycle.
  - else react = 1 -> pulse false_start, increment fail_count, go to GAP.
- MEASURE (trial_start = 1):
  - react_exceed = 1 -> fail, go to GAP. react_exceed has priority over a simultaneous react.
  - else react = 1 -> CAPTURE.
- CAPTURE (one cycle; t_react is sampled this cycle):
  - t_react < MIN_VALID -> fail.
  - otherwise valid:
    - sum += t_react;
    - if trial_idx == 0, load best_time and worst_time with t_react; else best = min, worst = max;
    - increment trial_idx.
  - then go to GAP.
- Fail handling: fail_count increments saturating at 255. If the new fail_count == MAX_FAILS -> ABORT instead of GAP.
- GAP (trial_start = 0):
  - counter runs 0..GAP_MS-1.
  - Leave only when the count has expired and react == 0.
  - If trial_idx == 2^LOG2_TRIALS -> FINISH, else -> ARM.
- FINISH (one cycle): avg_time = sum[LOG2_TRIALS +: 32] (truncating). Set session_done = 1, busy = 0, go to DONE.
- ABORT (one cycle): session_done = 1, session_abort = 1, avg_time = 0, busy = 0, trial_start = 0, go to DONE.
- DONE: all outputs hold until the next session_start edge or reset.
- Stat outputs update only in CAPTURE, FINISH and ABORT, so they are stable otherwise.
- trial_start is registered, and is high only in ARM, MEASURE and CAPTURE.

Test Plan:
- LOG2=2, MIN_VALID=100, GAP_MS=1000, MAX_FAILS=3. Session with t_react = 250, 300, 200, 350 -> best 200, worst 350, avg 275, fail_count 0, session_done=1, session_abort=0, trial_idx=4, busy=0.
- React asserted in ARM before random_finish -> false_start pulses for exactly 1 cycle, fail_count=1, trial_idx unchanged. trial_start stays low for at least 1000 cycles and until react is released, then re-arms.
- Timeout, then t_react = 63 -> react_exceed gives fail_count=1; 63 < 100 gives fail_count=2. Neither affects best, worst or sum. Following valid trials complete the session normally.
- Three consecutive fails -> ABORT, session_done=1, session_abort=1, avg_time=0, trial_start=0.
- Reset asserted mid-MEASURE -> next cycle all outputs 0 and trial_start=0. A session_start edge while busy does not restart the session or clear stats.
- Valid times 100, 101, 101, 101 -> sum 403, avg_time=100 (truncated). Boundary case: t_react = MIN_VALID is accepted as valid.

Source files
------------

// File: rtl/reaction_session_ctrl.sv
// reaction_session_ctrl: sequences a multi-trial reaction session, classifies trials and keeps best/worst/average stats
module reaction_session_ctrl #(
    parameter int LOG2_TRIALS = 2,
    parameter int MIN_VALID   = 100,
    parameter int GAP_MS      = 1000,
    parameter int MAX_FAILS   = 3
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   session_start_i,
    input  logic                   react_i,
    input  logic                   random_finish_i,
    input  logic                   react_exceed_i,
    input  logic [31:0]            t_react_i,
    output logic                   trial_start_o,
    output logic [LOG2_TRIALS:0]   trial_idx_o,
    output logic                   busy_o,
    output logic                   false_start_o,
    output logic [7:0]             fail_count_o,
    output logic [31:0]            best_time_o,
    output logic [31:0]            worst_time_o,
    output logic [31:0]            avg_time_o,
    output logic                   session_done_o,
    output logic                   session_abort_o
);
    localparam int GW = $clog2(GAP_MS + 1);

    typedef enum logic [2:0] {IDLE, ARM, MEASURE, CAPTURE, GAP, FINISH, ABORT, DONE} state_t;

    state_t                  state_q;
    logic                    start_q;
    logic [GW-1:0]           gap_q;
    logic [31+LOG2_TRIALS:0] sum_q;
    logic                    trial_start_q, busy_q, false_start_q, done_q, abort_q;
    logic [LOG2_TRIALS:0]    trial_idx_q;
    logic [7:0]              fail_count_q, fail_d;
    logic [31:0]             best_q, worst_q, avg_q;
    logic                    start_edge, gap_last, fail;

    // Trial outcome classification and saturating next fail count
    always_comb begin
        start_edge = session_start_i & ~start_q;
        gap_last   = gap_q == GW'(GAP_MS - 1);
        fail_d     = (fail_count_q == 8'hFF) ? fail_count_q : fail_count_q + 8'd1;
        fail       = (state_q == ARM && !random_finish_i && react_i) ||
                     (state_q == MEASURE && react_exceed_i) ||
                     (state_q == CAPTURE && t_react_i < 32'(MIN_VALID));
    end

    // Session FSM with registered outputs; a failed trial overrides the per-state transition
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            gap_q         <= '0;
            sum_q         <= '0;
            trial_start_q <= 1'b0;
            busy_q        <= 1'b0;
            false_start_q <= 1'b0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
            trial_idx_q   <= '0;
            fail_count_q  <= '0;
            best_q        <= '0;
            worst_q       <= '0;
            avg_q         <= '0;
        end else begin
            start_q       <= session_start_i;
            false_start_q <= 1'b0;
            case (state_q)
                IDLE, DONE: if (start_edge) begin
                    sum_q         <= '0;
                    trial_idx_q   <= '0;
                    fail_count_q  <= '0;
                    best_q        <= '0;
                    worst_q       <= '0;
                    avg_q         <= '0;
                    done_q        <= 1'b0;
                    abort_q       <= 1'b0;
                    busy_q        <= 1'b1;
                    trial_start_q <= 1'b1;
                    state_q       <= ARM;
                end
                ARM: begin
                    if (random_finish_i) state_q <= MEASURE;
                    else if (react_i) false_start_q <= 1'b1;
                end
                MEASURE: if (!react_exceed_i && react_i) state_q <= CAPTURE;
                CAPTURE: begin
                    trial_start_q <= 1'b0;
                    gap_q         <= '0;
                    state_q       <= GAP;
                    if (t_react_i >= 32'(MIN_VALID)) begin
                        sum_q       <= sum_q + (32 + LOG2_TRIALS)'(t_react_i);
                        best_q      <= (trial_idx_q == '0 || t_react_i < best_q) ? t_react_i : best_q;
                        worst_q     <= (trial_idx_q == '0 || t_react_i > worst_q) ? t_react_i : worst_q;
                        trial_idx_q <= trial_idx_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_last && !react_i) begin
                        state_q       <= trial_idx_q[LOG2_TRIALS] ? FINISH : ARM;
                        trial_start_q <= !trial_idx_q[LOG2_TRIALS];
                    end else if (!gap_last) gap_q <= gap_q + GW'(1);
                end
                FINISH: begin
                    avg_q   <= sum_q[LOG2_TRIALS +: 32];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= DONE;
                end
                ABORT: begin
                    avg_q         <= '0;
                    done_q        <= 1'b1;
                    abort_q       <= 1'b1;
                    busy_q        <= 1'b0;
                    trial_start_q <= 1'b0;
                    state_q       <= DONE;
                end
                default: state_q <= IDLE;
            endcase
            if (fail) begin
                fail_count_q  <= fail_d;
                trial_start_q <= 1'b0;
                gap_q         <= '0;
                state_q       <= (fail_d == 8'(MAX_FAILS)) ? ABORT : GAP;
            end
        end
    end

    assign trial_start_o   = trial_start_q;
    assign trial_idx_o     = trial_idx_q;
    assign busy_o          = busy_q;
    assign false_start_o   = false_start_q;
    assign fail_count_o    = fail_count_q;
    assign best_time_o     = best_q;
    assign worst_time_o    = worst_q;
    assign avg_time_o      = avg_q;
    assign session_done_o  = done_q;
    assign session_abort_o = abort_q;
endmodule

// File: tb/tb_reaction_session_ctrl.sv
// tb_reaction_session_ctrl: directed checks of session sequencing, trial classification and statistics
module tb_reaction_session_ctrl;
    logic        clk = 1'b0;
    logic        reset, session_start, react, random_finish, react_exceed;
    logic [31:0] t_react;
    logic        trial_start, busy, false_start, session_done, session_abort;
    logic [2:0]  trial_idx;
    logic [7:0]  fail_count;
    logic [31:0] best_time, worst_time, avg_time;
    int          vectors = 0;
    int          miscompares = 0;
    int          n;

    reaction_session_ctrl dut (
        .clock_i(clk), .reset_i(reset), .session_start_i(session_start), .react_i(react),
        .random_finish_i(random_finish), .react_exceed_i(react_exceed), .t_react_i(t_react),
        .trial_start_o(trial_start), .trial_idx_o(trial_idx), .busy_o(busy), .false_start_o(false_start),
        .fail_count_o(fail_count), .best_time_o(best_time), .worst_time_o(worst_time), .avg_time_o(avg_time),
        .session_done_o(session_done), .session_abort_o(session_abort)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input int idx, input int fc, input int b, input int w);
        chk({tag, "_idx"}, 32'(trial_idx), idx);
        chk({tag, "_fail"}, 32'(fail_count), fc);
        chk({tag, "_best"}, best_time, b);
        chk({tag, "_worst"}, worst_time, w);
    endtask

    task automatic chk_end(input string tag, input int avg, input int ab);
        chk({tag, "_avg"}, avg_time, avg);
        chk({tag, "_done"}, 32'(session_done), 1);
        chk({tag, "_abort"}, 32'(session_abort), ab);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ts"}, 32'(trial_start), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ts"}, 32'(trial_start), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fs"}, 32'(false_start), 0);
        chk({tag, "_done"}, 32'(session_done), 0);
        chk({tag, "_abort"}, 32'(session_abort), 0);
        chk({tag, "_avg"}, avg_time, 0);
        chk_stats(tag, 0, 0, 0, 0);
    endtask

    task automatic start_session();
        session_start = 1'b1;
        step();
        session_start = 1'b0;
    endtask

    task automatic trial(input logic [31:0] t, input logic early);
        react = early;
        random_finish = 1'b1;
        step();
        random_finish = 1'b0;
        react = 1'b1;
        t_react = t;
        step();
        step();
        react = 1'b0;
    endtask

    task automatic timeout_trial();
        random_finish = 1'b1;
        step();
        random_finish = 1'b0;
        react_exceed = 1'b1;
        react = 1'b1;
        step();
        react_exceed = 1'b0;
        react = 1'b0;
    endtask

    task automatic wait_gap(output int cnt);
        cnt = 0;
        while (!trial_start && !session_done && cnt < 3000) begin
            cnt++;
            step();
        end
        chk("gap_bound", 32'(cnt < 3000), 1);
    endtask

    initial begin
        reset = 1'b1; session_start = 1'b0; react = 1'b0; random_finish = 1'b0;
        react_exceed = 1'b0; t_react = 32'd0;
        step(); step();
        chk_zero("rst");
        reset = 1'b0;
        step();

        // Session A: four valid trials
        start_session();
        chk("a_busy", 32'(busy), 1);
        chk("a_ts", 32'(trial_start), 1);
        trial(250, 1'b0);
        chk_stats("a1", 1, 0, 250, 250);
        chk("a1_ts", 32'(trial_start), 0);
        wait_gap(n);
        chk("a_gap_len", n, 1000);
        trial(300, 1'b0); wait_gap(n);
        trial(200, 1'b0); wait_gap(n);
        trial(350, 1'b0);
        chk_stats("a4", 4, 0, 200, 350);
        chk("a4_avg_hold", avg_time, 0);
        wait_gap(n);
        chk_stats("a_end", 4, 0, 200, 350);
        chk_end("a_end", 275, 0);

        // Session B: false start with react held through the gap, then boundary values
        start_session();
        chk("b_clr_best", best_time, 0);
        chk("b_clr_done", 32'(session_done), 0);
        react = 1'b1;
        step();
        chk("b_fs_pulse", 32'(false_start), 1);
        chk_stats("b_fs", 0, 1, 0, 0);
        chk("b_fs_ts", 32'(trial_start), 0);
        step();
        chk("b_fs_one", 32'(false_start), 0);
        for (int i = 0; i < 1200; i++) step();
        chk("b_held_ts", 32'(trial_start), 0);
        react = 1'b0;
        step();
        chk("b_rearm_ts", 32'(trial_start), 1);
        trial(100, 1'b0); wait_gap(n);
        trial(101, 1'b0); wait_gap(n);
        trial(101, 1'b0); wait_gap(n);
        trial(101, 1'b0); wait_gap(n);
        chk_stats("b_end", 4, 1, 100, 101);
        chk_end("b_end", 100, 0);

        // Session C: timeout, anticipation, then valid trials with early react in ARM
        start_session();
        timeout_trial();
        chk_stats("c_to", 0, 1, 0, 0);
        chk("c_to_ts", 32'(trial_start), 0);
        wait_gap(n);
        trial(63, 1'b0);
        chk_stats("c_ant", 0, 2, 0, 0);
        wait_gap(n);
        trial(500, 1'b1);
        chk("c_prio_fs", 32'(false_start), 0);
        chk_stats("c1", 1, 2, 500, 500);
        wait_gap(n);
        trial(400, 1'b0); wait_gap(n);
        trial(600, 1'b0); wait_gap(n);
        trial(700, 1'b0); wait_gap(n);
        chk_stats("c_end", 4, 2, 400, 700);
        chk_end("c_end", 550, 0);

        // Session D: three consecutive fails abort
        start_session();
        react = 1'b1;
        step();
        react = 1'b0;
        wait_gap(n);
        timeout_trial();
        wait_gap(n);
        trial(50, 1'b0);
        chk("d_fail3", 32'(fail_count), 3);
        chk("d_abort_ts", 32'(trial_start), 0);
        step();
        chk_stats("d_end", 0, 3, 0, 0);
        chk_end("d_end", 0, 1);
        for (int i = 0; i < 20; i++) step();
        chk("d_hold_done", 32'(session_done), 1);

        // Session E: restart edge while busy is ignored, reset mid-MEASURE clears all
        start_session();
        trial(250, 1'b0);
        step();
        start_session();
        step();
        chk_stats("e_ign", 1, 0, 250, 250);
        chk("e_ign_busy", 32'(busy), 1);
        chk("e_ign_ts", 32'(trial_start), 0);
        wait_gap(n);
        random_finish = 1'b1;
        step();
        random_finish = 1'b0;
        reset = 1'b1;
        step();
        chk_zero("e_rst");
        reset = 1'b0;
        step();
        chk_zero("e_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
